tilt_zone_indicator: RTL and testbench

Parametrised successor of the per-axis tilt LED indicator. Classifies each of N_CH angle channels into LOW / MID / HIGH zones, using hysteresis and a persistence filter so that LEDs do not chatter near the thresholds. Sits between the angle-estimation datapath and the board LED pins. Each channel drives 4 LEDs: bit0 = LOW, bits 1-2 = MID, bit3 = HIGH.

---
 rtl/tilt_zone_indicator.sv | 178 +++++++++++++++++
 tb/tb_tilt_zone_indicator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/tilt_zone_indicator.sv
// tilt_zone_indicator: classifies each of N_CH unsigned angle channels into
// LOW / MID / HIGH, using hysteresis and a persistence filter, and drives
// four LEDs per channel (bit0 LOW, bits1-2 MID, bit3 HIGH).
// Optional feature macro: TILT_BLINK_EN. When it is defined, the LOW and HIGH
// LEDs blink with a half-period of BLINK_DIV cycles. The MID LEDs and the zone
// output stay steady.
module tilt_zone_indicator #(
  parameter int unsigned N_CH      = 2,
  parameter int unsigned W         = 8,
  parameter int unsigned LOW_TH    = 90,
  parameter int unsigned HIGH_TH   = 180,
  parameter int unsigned HYST      = 4,
  parameter int unsigned PERSIST   = 3,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH*W-1:0]   angle,
  input  logic                angle_valid,
  output logic [4*N_CH-1:0]   leds,
  output logic [2*N_CH-1:0]   zone
);

  localparam int unsigned WX = W + 1;
  localparam int unsigned CW = (PERSIST > 0) ? $clog2(PERSIST + 1) : 1;

  // The band edges must not overlap, the persistence must be non-zero and the
  // blink divider must be non-zero.
  localparam bit PARAMS_OK =
    (int'(LOW_TH) + int'(HYST) < int'(HIGH_TH) - int'(HYST)) &&
    (HYST <= LOW_TH) && (PERSIST >= 1) && (BLINK_DIV >= 1);

  // Stop elaboration when the parameter set is illegal.
  if (!PARAMS_OK) begin : g_param_check
    $fatal(1, "tilt_zone_indicator: illegal parameter set");
  end

  // Thresholds are widened by one bit, so LOW_TH+HYST cannot wrap.
  localparam logic [WX-1:0] LO_TH = WX'(LOW_TH);
  localparam logic [WX-1:0] LO_HY = WX'(LOW_TH + HYST);
  localparam logic [WX-1:0] HI_TH = WX'(HIGH_TH);
  localparam logic [WX-1:0] HI_HY = WX'(HIGH_TH - HYST);

  typedef enum logic [1:0] {
    ZONE_LOW  = 2'b00,
    ZONE_MID  = 2'b01,
    ZONE_HIGH = 2'b10
  } zone_t;

  // The target zone of a sample, given the committed zone (hysteresis applies
  // only when leaving LOW or HIGH).
  function automatic zone_t target_f(input zone_t z, input logic [WX-1:0] a);
    zone_t t;
    case (z)
      ZONE_LOW: begin
        if (a >= HI_TH)      t = ZONE_HIGH;
        else if (a > LO_HY)  t = ZONE_MID;
        else                 t = ZONE_LOW;
      end
      ZONE_HIGH: begin
        if (a <= LO_TH)      t = ZONE_LOW;
        else if (a < HI_HY)  t = ZONE_MID;
        else                 t = ZONE_HIGH;
      end
      default: begin
        if (a <= LO_TH)      t = ZONE_LOW;
        else if (a >= HI_TH) t = ZONE_HIGH;
        else                 t = ZONE_MID;
      end
    endcase
    return t;
  endfunction

  // The steady LED pattern of a committed zone.
  function automatic logic [3:0] decode_f(input zone_t z);
    logic [3:0] l;
    case (z)
      ZONE_LOW:  l = 4'b0001;
      ZONE_HIGH: l = 4'b1000;
      default:   l = 4'b0110;
    endcase
    return l;
  endfunction

  zone_t          zone_q   [N_CH];
  zone_t          cand_q   [N_CH];
  logic [CW-1:0]  cnt_q    [N_CH];
  zone_t          zone_nxt [N_CH];
  zone_t          cand_nxt [N_CH];
  logic [CW-1:0]  cnt_nxt  [N_CH];
  zone_t          tgt_c    [N_CH];
  logic [CW-1:0]  run_c    [N_CH];
  logic [3:0]     blink_mask;

`ifdef TILT_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic          phase_nxt;

  // The blink phase toggles each time the divider wraps.
  always_comb begin
    phase_nxt = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) phase_nxt = ~phase_q;
  end

  // A free-running blink divider.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= (blink_cnt_q == BW'(BLINK_DIV - 1)) ? '0 : blink_cnt_q + BW'(1);
      phase_q     <= phase_nxt;
    end
  end

  assign blink_mask = {phase_nxt, 2'b11, phase_nxt};
`else
  assign blink_mask = 4'b1111;
`endif

  // Per channel: the target zone and the length the run would reach.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      tgt_c[i] = target_f(zone_q[i], {1'b0, angle[i*W +: W]});
      run_c[i] = (tgt_c[i] == cand_q[i]) ? cnt_q[i] + CW'(1) : CW'(1);
    end
  end

  // The persistence filter. It advances only on valid samples.
  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      zone_nxt[i] = zone_q[i];
      cand_nxt[i] = cand_q[i];
      cnt_nxt[i]  = cnt_q[i];
      if (angle_valid) begin
        if (tgt_c[i] == zone_q[i]) begin
          cnt_nxt[i] = '0;
        end else begin
          cand_nxt[i] = tgt_c[i];
          if (run_c[i] >= CW'(PERSIST)) begin
            zone_nxt[i] = tgt_c[i];
            cnt_nxt[i]  = '0;
          end else begin
            cnt_nxt[i] = run_c[i];
          end
        end
      end
    end
  end

  // The state and the registered LED outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N_CH); i++) begin
        zone_q[i]       <= ZONE_MID;
        cand_q[i]       <= ZONE_MID;
        cnt_q[i]        <= '0;
        leds[4*i +: 4]  <= 4'b0110;
      end
    end else begin
      for (int i = 0; i < int'(N_CH); i++) begin
        zone_q[i]       <= zone_nxt[i];
        cand_q[i]       <= cand_nxt[i];
        cnt_q[i]        <= cnt_nxt[i];
        leds[4*i +: 4]  <= decode_f(zone_nxt[i]) & blink_mask;
      end
    end
  end

  // The zone output is the committed-zone register.
  for (genvar g = 0; g < int'(N_CH); g++) begin : g_zone
    assign zone[2*g +: 2] = zone_q[g];
  end

endmodule

// File: tb/tb_tilt_zone_indicator.sv
// Self-checking bench for tilt_zone_indicator. It drives directed sequences
// and random sequences, and a monitor compares every clock edge against a
// behavioural model.
module tb_tilt_zone_indicator;

  localparam int N_CH      = 2;
  localparam int W         = 8;
  localparam int LOW_TH    = 90;
  localparam int HIGH_TH   = 180;
  localparam int HYST      = 4;
  localparam int PERSIST   = 3;
  localparam int BLINK_DIV = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [N_CH*W-1:0]   angle;
  logic                angle_valid;
  logic [4*N_CH-1:0]   leds;
  logic [2*N_CH-1:0]   zone;

  tilt_zone_indicator #(
    .N_CH(N_CH), .W(W), .LOW_TH(LOW_TH), .HIGH_TH(HIGH_TH),
    .HYST(HYST), .PERSIST(PERSIST), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .angle(angle), .angle_valid(angle_valid),
    .leds(leds), .zone(zone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  // Model state: zone (0 LOW, 1 MID, 2 HIGH), candidate, run length, and the
  // number of edges since reset.
  int mz[N_CH];
  int mc[N_CH];
  int mn[N_CH];
  int edges;

  function automatic int target(input int z, input int a);
    if (z == 0) return (a >= HIGH_TH) ? 2 : (a > LOW_TH + HYST) ? 1 : 0;
    if (z == 2) return (a <= LOW_TH) ? 0 : (a < HIGH_TH - HYST) ? 1 : 2;
    return (a <= LOW_TH) ? 0 : (a >= HIGH_TH) ? 2 : 1;
  endfunction

  function automatic logic [3:0] led_of(input int z, input int e);
    logic [3:0] l;
    l = (z == 0) ? 4'b0001 : (z == 2) ? 4'b1000 : 4'b0110;
`ifdef TILT_BLINK_EN
    if (z != 1 && ((e / BLINK_DIV) % 2) == 0) l = 4'b0000;
`else
    if (e < 0) l = 4'b0000;
`endif
    return l;
  endfunction

  task automatic model_edge(input logic r, input logic v, input int a0, input int a1);
    int a[N_CH];
    int t;
    logic [11:0] e;
    a[0] = a0;
    a[1] = a1;
    if (r) begin
      for (int i = 0; i < N_CH; i++) begin
        mz[i] = 1; mc[i] = 1; mn[i] = 0;
      end
      edges = 0;
    end else begin
      edges++;
      if (v) begin
        for (int i = 0; i < N_CH; i++) begin
          t = target(mz[i], a[i]);
          if (t == mz[i]) mn[i] = 0;
          else begin
            mn[i] = (t == mc[i]) ? mn[i] + 1 : 1;
            mc[i] = t;
            if (mn[i] >= PERSIST) begin
              mz[i] = t; mn[i] = 0;
            end
          end
        end
      end
    end
    if (r) e = {8'b0110_0110, 4'b0101};
    else e = {led_of(mz[1], edges), led_of(mz[0], edges), 2'(mz[1]), 2'(mz[0])};
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus and queue the expected response to its edge.
  task automatic step(input logic r, input logic v, input int a0, input int a1);
    @(negedge clk);
    rst = r;
    angle_valid = v;
    angle = {8'(a1), 8'(a0)};
    model_edge(r, v, a0, a1);
  endtask

  task automatic steps(input int n, input logic v, input int a0, input int a1);
    for (int k = 0; k < n; k++) step(1'b0, v, a0, a1);
  endtask

  // A directed check against constants, taken just after the edge.
  task automatic dcheck(input string name, input logic [7:0] el, input logic [3:0] ez);
    @(posedge clk);
    #2;
    checks++;
    if (leds !== el || zone !== ez) begin
      errors++;
      $display("FAIL %s leds=%b zone=%b expected leds=%b zone=%b", name, leds, zone, el, ez);
    end
  endtask

  // Monitor: compares the DUT with the oldest queued expectation after every edge.
  initial begin
    logic [11:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({leds, zone} !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t leds=%b zone=%b expected leds=%b zone=%b",
                   $time, leds, zone, e[11:4], e[3:0]);
        end
      end
    end
  end

  initial begin
    int a0, a1, m;
    logic v;
    rst = 1'b1;
    angle_valid = 1'b0;
    angle = '0;

    // The reset, then idle cycles.
    steps(0, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0);
    steps(10, 1'b0, 0, 0);
    // The persistence filter, and an interrupted run.
    steps(2, 1'b1, 80, 130);
    steps(1, 1'b1, 120, 130);
    steps(3, 1'b1, 80, 130);
`ifndef TILT_BLINK_EN
    dcheck("persist_low", 8'b0110_0001, 4'b0100);
`endif
    // Hysteresis around LOW, then around HIGH.
    steps(6, 1'b1, 93, 130);
    steps(3, 1'b1, 95, 130);
    steps(3, 1'b1, 200, 130);
    steps(5, 1'b1, 177, 130);
    steps(3, 1'b1, 175, 130);
`ifndef TILT_BLINK_EN
    dcheck("hyst_mid", 8'b0110_0110, 4'b0101);
`endif
    // A direct jump on ch1, with ch0 independent.
    steps(3, 1'b1, 130, 200);
`ifndef TILT_BLINK_EN
    dcheck("ch1_high", 8'b1000_0110, 4'b1001);
`endif
    steps(3, 1'b1, 130, 10);
`ifndef TILT_BLINK_EN
    dcheck("ch1_jump_low", 8'b0001_0110, 4'b0001);
`endif
    // Gaps between samples, and a reset that clears the run.
    steps(1, 1'b1, 130, 130);
    steps(1, 1'b1, 200, 130);
    steps(5, 1'b0, 200, 130);
    steps(1, 1'b1, 200, 130);
    step(1'b1, 1'b0, 200, 130);
    steps(1, 1'b1, 200, 130);
    steps(2, 1'b1, 200, 130);
`ifndef TILT_BLINK_EN
    dcheck("gap_reset_high", 8'b0110_1000, 4'b0110);
`endif
    // Hold HIGH so that any blinking is exercised.
    steps(12, 1'b1, 200, 130);

    // Random phase: the angles cluster near the thresholds and are often held.
    a0 = 130;
    a1 = 130;
    for (int k = 0; k < 3000; k++) begin
      m = $urandom_range(0, 7);
      if (m == 0) begin a0 = $urandom_range(0, 255); a1 = $urandom_range(0, 255); end
      else if (m == 1) a0 = $urandom_range(86, 98);
      else if (m == 2) a0 = $urandom_range(172, 184);
      else if (m == 3) a1 = $urandom_range(84, 100);
      else if (m == 4) a1 = $urandom_range(170, 186);
      v = ($urandom_range(0, 9) < 7);
      step(($urandom_range(0, 199) == 0), v, a0, a1);
    end

    step(1'b0, 1'b0, a0, a1);
    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
